alu_seq: RTL

//  Parametrised, multi-cycle successor to the datapath ALU. Operand selection is register/immediate/PC.

---
 rtl/alu_pkg.sv | 34 +++
 rtl/alu_iter_unit.sv | 81 ++++++++
 rtl/alu_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, operand-source and state encodings for the sequential ALU.
// The helper below selects which operations run on the iterative unit.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_AND = 3'b001,
    OP_NOT = 3'b010,
    OP_XOR = 3'b011,
    OP_SHL = 3'b100,
    OP_SHR = 3'b101,
    OP_SRA = 3'b110,
    OP_MUL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IMM     = 2'b00,
    SRC_PC      = 2'b01,
    SRC_REG     = 2'b10,
    SRC_REG_ALT = 2'b11
  } src_sel_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Shifts and multiply take the iterative path; everything else completes in one cycle.
  function automatic logic is_iter_op(input alu_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/alu_iter_unit.sv
// Iterative shift / shift-add multiply engine. One bit of work per cycle;
// o_result presents the value after the current cycle's iteration so o_done can be consumed directly.
module alu_iter_unit
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_start,
  input  alu_op_e           i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic              o_busy,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result
);

  localparam int unsigned SHW   = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  alu_op_e           r_op;
  logic              r_busy;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_mcand;
  logic [DATA_W-1:0] r_mplr;
  logic [DATA_W-1:0] w_acc_nxt;
  logic [CNT_W-1:0]  w_cnt_init;

  always_comb begin
    w_cnt_init = (i_op == OP_MUL) ? CNT_W'(DATA_W) : CNT_W'(i_b[SHW-1:0]);
  end

  // A zero count still spends one cycle here, leaving the operand untouched.
  always_comb begin
    w_acc_nxt = r_acc;
    if (r_cnt != '0) begin
      case (r_op)
        OP_SHL:  w_acc_nxt = {r_acc[DATA_W-2:0], 1'b0};
        OP_SHR:  w_acc_nxt = {1'b0, r_acc[DATA_W-1:1]};
        OP_SRA:  w_acc_nxt = {r_acc[DATA_W-1], r_acc[DATA_W-1:1]};
        OP_MUL:  w_acc_nxt = r_acc + (r_mplr[0] ? r_mcand : '0);
        default: w_acc_nxt = r_acc;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_ADD;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_mcand <= '0;
      r_mplr  <= '0;
    end else if (i_start) begin
      r_busy  <= 1'b1;
      r_op    <= i_op;
      r_cnt   <= w_cnt_init;
      r_acc   <= (i_op == OP_MUL) ? '0 : i_a;
      r_mcand <= i_a;
      r_mplr  <= i_b;
    end else if (r_busy) begin
      r_acc   <= w_acc_nxt;
      r_mcand <= r_mcand << 1;
      r_mplr  <= r_mplr >> 1;
      if (r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (o_done) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_busy && (r_cnt <= CNT_W'(1));
  assign o_result = w_acc_nxt;

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle ALU between register read and writeback: operand mux, single-cycle ops,
// handshake FSM and registered NZP/carry/overflow flags. Iterative ops are delegated to alu_iter_unit.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMM_W  = 6,
  parameter int unsigned PC_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        alu_op,
  input  logic [1:0]        source_sel,
  input  logic [IMM_W-1:0]  ins_immediate,
  input  logic [PC_W-1:0]   pc,
  input  logic [DATA_W-1:0] reg_sr1_out,
  input  logic [DATA_W-1:0] reg_sr2_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] result,
  output logic              negative,
  output logic              zero,
  output logic              positive,
  output logic              carry,
  output logic              overflow
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [DATA_W-1:0] r_result;
  logic              r_neg;
  logic              r_zero;
  logic              r_pos;
  logic              r_carry;
  logic              r_ovf;

  alu_op_e           w_op;
  src_sel_e          w_sel;
  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_a;
  logic [DATA_W-1:0] w_b;
  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_single;
  logic              w_single_c;
  logic              w_single_v;
  logic              w_accept;
  logic              w_in_ready;

  logic              w_iter_start;
  logic              w_iter_busy;
  logic              w_iter_done;
  logic [DATA_W-1:0] w_iter_result;

  logic              w_load;
  logic [DATA_W-1:0] w_load_val;
  logic              w_load_c;
  logic              w_load_v;

  assign w_op       = alu_op_e'(alu_op);
  assign w_sel      = src_sel_e'(source_sel);
  assign w_imm_sext = {{(DATA_W-IMM_W+1){ins_immediate[IMM_W-2]}}, ins_immediate[IMM_W-2:0]};

  always_comb begin
    w_a = reg_sr1_out;
    w_b = reg_sr2_out;
    case (w_sel)
      SRC_IMM: w_b = w_imm_sext;
      SRC_PC: begin
        w_a = DATA_W'(pc);
        w_b = DATA_W'(ins_immediate);
      end
      default: ;
    endcase
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b};

  always_comb begin
    w_single   = '0;
    w_single_c = 1'b0;
    w_single_v = 1'b0;
    case (w_op)
      OP_ADD: begin
        w_single   = w_sum[DATA_W-1:0];
        w_single_c = w_sum[DATA_W];
        w_single_v = (w_a[DATA_W-1] == w_b[DATA_W-1]) && (w_sum[DATA_W-1] != w_a[DATA_W-1]);
      end
      OP_AND:  w_single = w_a & w_b;
      OP_NOT:  w_single = ~w_b;
      OP_XOR:  w_single = w_a ^ w_b;
      default: ;
    endcase
  end

  // Busy term never overlaps IDLE/DONE; it only guards against restarting the unit mid-operation.
  assign w_in_ready = ((r_state == IDLE) || ((r_state == DONE) && out_ready)) && !w_iter_busy;
  assign w_accept   = in_valid && w_in_ready;

  alu_iter_unit #(
    .DATA_W (DATA_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_start  (w_iter_start),
    .i_op     (w_op),
    .i_a      (w_a),
    .i_b      (w_b),
    .o_busy   (w_iter_busy),
    .o_done   (w_iter_done),
    .o_result (w_iter_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // An accept in DONE retires the held result and starts the new op on the same edge.
  always_comb begin
    w_state_nxt  = r_state;
    w_iter_start = 1'b0;
    w_load       = 1'b0;
    w_load_val   = w_single;
    w_load_c     = w_single_c;
    w_load_v     = w_single_v;
    case (r_state)
      EXEC: begin
        if (w_iter_done) begin
          w_state_nxt = DONE;
          w_load      = 1'b1;
          w_load_val  = w_iter_result;
          w_load_c    = 1'b0;
          w_load_v    = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: ;
    endcase
    if (w_accept) begin
      if (is_iter_op(w_op)) begin
        w_state_nxt  = EXEC;
        w_iter_start = 1'b1;
      end else begin
        w_state_nxt = DONE;
        w_load      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_neg    <= 1'b0;
      r_zero   <= 1'b1;
      r_pos    <= 1'b0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_result <= w_load_val;
      r_neg    <= w_load_val[DATA_W-1];
      r_zero   <= (w_load_val == '0);
      r_pos    <= !w_load_val[DATA_W-1] && (|w_load_val);
      r_carry  <= w_load_c;
      r_ovf    <= w_load_v;
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = (r_state == DONE);
  assign result    = r_result;
  assign negative  = r_neg;
  assign zero      = r_zero;
  assign positive  = r_pos;
  assign carry     = r_carry;
  assign overflow  = r_ovf;

endmodule
